// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
//  - default geometry (lines, index width, counter width)
//  - controller state encoding and backing-memory request payload
//  - LW/SW opcode constants shared with the pipeline decode
package dcache_mem_ctrl_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEF_LINES = 4;
  localparam int unsigned DEF_IDX_W = 2;
  localparam int unsigned DEF_CNT_W = 16;

  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_e;

  // Payload presented to the backing memory; held stable until accepted.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dcache_mem_ctrl_line_array.sv
// Valid/tag/data storage for the direct-mapped cache.
//  clk_i, rst_ni      : clock, async active-low reset (clears valid bits only)
//  clear_all_i        : invalidate every line on the next edge (flush)
//  rd_idx_i           : combinational read port index
//  rd_valid_o/tag/data: contents of the indexed line
//  we_i, wr_*_i       : synchronous write of tag+data, sets the line valid
module dcache_mem_ctrl_line_array
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned IDX_W = DEF_IDX_W,
  parameter int unsigned TAG_W = ADDR_W - DEF_IDX_W - 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_all_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Valid bits: only state that needs reset; clear-all beats a write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data payload, qualified by valid so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with a blocking
// miss handler between the MEM stage and the backing data memory.
//  clk_i, rst_ni            : clock, async active-low reset
//  req_*_i / req_ready_o    : MEM-stage access; req_ready_o low stalls the pipe
//  resp_valid_o/rdata_o     : one-cycle completion pulse (rdata 0 for stores)
//  flush_i                  : invalidate all lines (acted on only when idle)
//  mem_*                    : backing memory request/response channel
//  hit_cnt_o / miss_cnt_o   : saturating load hit/miss counters
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned IDX_W = DEF_IDX_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  state_e            state_q, state_d;
  mem_req_t          mreq_q, mreq_d;
  logic              mreq_valid_q, mreq_valid_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic              accept_c;
  logic              hit_c;
  logic              fill_c;
  logic [IDX_W-1:0]  req_idx_c, fill_idx_c;
  logic [TAG_W-1:0]  req_tag_c, fill_tag_c;
  logic              line_valid_c;
  logic [TAG_W-1:0]  line_tag_c;
  logic [DATA_W-1:0] line_data_c;
  logic              arr_we_c, arr_clear_c;
  logic [IDX_W-1:0]  arr_idx_c;
  logic [TAG_W-1:0]  arr_tag_c;
  logic [DATA_W-1:0] arr_data_c;
  logic              unused_addr_lsb;

  // Byte offset within the word carries no information for word accesses.
  assign unused_addr_lsb = ^req_addr_i[1:0];

  assign req_idx_c  = req_addr_i[IDX_W+1:2];
  assign req_tag_c  = req_addr_i[ADDR_W-1:IDX_W+2];
  assign fill_idx_c = mreq_q.addr[IDX_W+1:2];
  assign fill_tag_c = mreq_q.addr[ADDR_W-1:IDX_W+2];

  assign req_ready_o = (state_q == ST_IDLE) && !flush_i;
  assign accept_c    = req_valid_i && req_ready_o;
  assign hit_c       = line_valid_c && (line_tag_c == req_tag_c);
  // Flush is a level; outside IDLE it is simply not looked at.
  assign arr_clear_c = flush_i && (state_q == ST_IDLE);

  dcache_mem_ctrl_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_all_i (arr_clear_c),
    .rd_idx_i    (req_idx_c),
    .rd_valid_o  (line_valid_c),
    .rd_tag_o    (line_tag_c),
    .rd_data_o   (line_data_c),
    .we_i        (arr_we_c),
    .wr_idx_i    (arr_idx_c),
    .wr_tag_i    (arr_tag_c),
    .wr_data_i   (arr_data_c)
  );

  // Next-state, memory request, response and counter logic.
  always_comb begin
    state_d      = state_q;
    mreq_d       = mreq_q;
    mreq_valid_d = mreq_valid_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    hit_d        = hit_q;
    miss_d       = miss_q;
    fill_c       = 1'b0;
    arr_we_c     = 1'b0;
    arr_idx_c    = req_idx_c;
    arr_tag_c    = req_tag_c;
    arr_data_c   = req_wdata_i;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (req_write_i) begin
            // Write-through; a store hit refreshes the line, a miss leaves it.
            mreq_d       = '{we: 1'b1, addr: word_align(req_addr_i), wdata: req_wdata_i};
            mreq_valid_d = 1'b1;
            arr_we_c     = hit_c;
            state_d      = ST_WR_REQ;
          end else if (hit_c) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = line_data_c;
            if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
          end else begin
            mreq_d       = '{we: 1'b0, addr: word_align(req_addr_i), wdata: '0};
            mreq_valid_d = 1'b1;
            if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
            state_d      = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (mem_req_ready_i) begin
          mreq_valid_d = 1'b0;
          // Data returning with the handshake completes the fill immediately.
          if (mem_rvalid_i) fill_c = 1'b1;
          else              state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (mem_rvalid_i) fill_c = 1'b1;
      end
      ST_WR_REQ: begin
        if (mem_req_ready_i) begin
          mreq_valid_d = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fill_c) begin
      arr_we_c     = 1'b1;
      arr_idx_c    = fill_idx_c;
      arr_tag_c    = fill_tag_c;
      arr_data_c   = mem_rdata_i;
      resp_valid_d = 1'b1;
      resp_rdata_d = mem_rdata_i;
      state_d      = ST_IDLE;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      mreq_q       <= '0;
      mreq_valid_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      mreq_q       <= mreq_d;
      mreq_valid_q <= mreq_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign resp_valid_o    = resp_valid_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign mem_req_valid_o = mreq_valid_q;
  assign mem_we_o        = mreq_q.we;
  assign mem_addr_o      = mreq_q.addr;
  assign mem_wdata_o     = mreq_q.wdata;
  assign hit_cnt_o       = hit_q;
  assign miss_cnt_o      = miss_q;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Scoreboard bench for dcache_mem_ctrl: directed scenarios followed by
// randomized loads/stores/flushes against an abstract cache+memory model.
module tb_dcache_mem_ctrl;

  localparam int unsigned LINES = 4;
  localparam int unsigned CMAX  = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        flush = 1'b0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [15:0] hit_cnt, miss_cnt;

  dcache_mem_ctrl dut (
    .clk_i (clk), .rst_ni (rst_n),
    .req_valid_i (req_valid), .req_ready_o (req_ready), .req_write_i (req_write),
    .req_addr_i (req_addr), .req_wdata_i (req_wdata),
    .resp_valid_o (resp_valid), .resp_rdata_o (resp_rdata), .flush_i (flush),
    .mem_req_valid_o (mem_req_valid), .mem_req_ready_i (mem_req_ready), .mem_we_o (mem_we),
    .mem_addr_o (mem_addr), .mem_wdata_o (mem_wdata),
    .mem_rvalid_i (mem_rvalid), .mem_rdata_i (mem_rdata),
    .hit_cnt_o (hit_cnt), .miss_cnt_o (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    logic [31:0] rdata;
    int unsigned hitc, missc, rd, wr;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0;
  int          cyc = 0;
  // Reference model: memory image plus which word each line currently holds.
  logic [31:0] ref_mem [int unsigned];
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  int unsigned m_hits = 0, m_miss = 0, m_rd = 0, m_wr = 0;
  // Backing memory responder state and knobs.
  logic [31:0] bmem [int unsigned];
  int unsigned rd_hs = 0, wr_hs = 0;
  int          fix_ready = -1, fix_rd = -1;
  bit          hold_read = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] wa);
    if (ref_mem.exists(int'(wa))) return ref_mem[int'(wa)];
    return init_val(wa);
  endfunction

  function automatic logic [31:0] bmem_read(input logic [31:0] wa);
    if (bmem.exists(int'(wa))) return bmem[int'(wa)];
    return init_val(wa);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endfunction

  // Backing memory: random accept delay, random read return delay.
  initial begin : responder
    int          rwait, rdly;
    bit          rpend;
    logic [31:0] rdat;
    rwait = -1; rdly = 0; rpend = 1'b0; rdat = '0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      if (!rst_n) begin
        rwait = -1;
        continue;
      end
      if (rpend && !hold_read) begin
        if (rdly == 0) begin
          mem_rvalid = 1'b1; mem_rdata = rdat; rpend = 1'b0;
        end else rdly--;
      end
      if (mem_req_valid) begin
        if (rwait < 0) rwait = (fix_ready >= 0) ? fix_ready : int'($urandom_range(0, 3));
        if (rwait == 0) begin
          mem_req_ready = 1'b1;
          rwait = -1;
          if (mem_we) begin
            bmem[int'(mem_addr)] = mem_wdata;
            wr_hs++;
          end else begin
            rd_hs++;
            rdat = bmem_read(mem_addr);
            rdly = (fix_rd >= 0) ? fix_rd : int'($urandom_range(0, 3));
            if (rdly == 0 && !hold_read) begin
              mem_rvalid = 1'b1; mem_rdata = rdat;
            end else rpend = 1'b1;
          end
        end else rwait--;
      end
    end
  end

  // Memory request must hold steady while waiting for acceptance.
  initial begin : stability
    logic        pv, pr, pwe;
    logic [31:0] pa, pd;
    logic        prst;
    pv = 1'b0; pr = 1'b0; pwe = 1'b0; pa = '0; pd = '0; prst = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && prst && pv && !pr) begin
        chk("mem_req_valid_held", 32'(mem_req_valid), 32'd1);
        chk("mem_we_held", 32'(mem_we), 32'(pwe));
        chk("mem_addr_held", mem_addr, pa);
        chk("mem_wdata_held", mem_wdata, pd);
      end
      pv = mem_req_valid; pr = mem_req_ready; pwe = mem_we;
      pa = mem_addr; pd = mem_wdata; prst = rst_n;
    end
  end

  // Scoreboard monitor: every response pops the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp actual=0x%08h required=no_response t=%0t", resp_rdata, $time);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("hit_cnt", 32'(hit_cnt), e.hitc);
          chk("miss_cnt", 32'(miss_cnt), e.missc);
          chk("mem_reads", rd_hs, e.rd);
          chk("mem_writes", wr_hs, e.wr);
          if (e.hit) chk("hit_latency", 32'(cyc - e.acc_cyc), 32'd1);
        end
      end
    end
  end

  // Compute expectation from the model, then present and hold until accepted.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, output bit was_hit);
    exp_t        e;
    int          n;
    int unsigned idx;
    logic [31:0] wa, tg;
    wa  = {a[31:2], 2'b00};
    idx = (a >> 2) % LINES;
    tg  = a >> 4;
    e.hit = 1'b0;
    e.rdata = '0;
    if (w) begin
      ref_mem[int'(wa)] = d;
      m_wr++;
    end else begin
      e.rdata = ref_read(wa);
      if (m_valid[idx] && m_tag[idx] == tg) begin
        e.hit = 1'b1;
        if (m_hits < CMAX) m_hits++;
      end else begin
        if (m_miss < CMAX) m_miss++;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_rd++;
      end
    end
    e.hitc = m_hits; e.missc = m_miss; e.rd = m_rd; e.wr = m_wr;
    was_hit = e.hit;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    #1;
    n = 0;
    while (!req_ready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 300) begin
        checks++; failures++;
        $display("FAIL accept_timeout actual=stalled required=accept addr=0x%08h", a);
        req_valid = 1'b0;
        return;
      end
    end
    e.acc_cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_reset_lines();
  endtask

  function automatic void model_reset_lines();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : driver
    bit h;
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Cold miss, then hit on the same word.
    bmem[32'h10] = 32'h0000_CAFE;
    ref_mem[32'h10] = 32'h0000_CAFE;
    fix_ready = 0; fix_rd = 3;
    issue(1'b0, 32'h10, '0, h);
    wait_idle();
    issue(1'b0, 32'h10, '0, h);
    wait_idle();
    // Store hit under a slow accept, then read it back.
    fix_ready = 2;
    issue(1'b1, 32'h10, 32'h1234, h);
    issue(1'b0, 32'h10, '0, h);
    // Store miss does not allocate.
    fix_ready = 0; fix_rd = 0;
    issue(1'b1, 32'h20, 32'hBEEF_0020, h);
    issue(1'b0, 32'h20, '0, h);
    // Same index, alternating tags.
    issue(1'b0, 32'h00, '0, h);
    issue(1'b0, 32'h40, '0, h);
    issue(1'b0, 32'h00, '0, h);
    wait_idle();

    // Reset while a read is outstanding; late data must be ignored.
    hold_read = 1'b1; fix_rd = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h70;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    m_rd++;
    n = 0;
    while (rd_hs != m_rd && n < 50) begin @(negedge clk); n++; end
    chk("abort_mem_handshake", rd_hs, m_rd);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("abort_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_read = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("abort_no_resp_queue", sb.size(), 32'd0);
    issue(1'b0, 32'h70, '0, h);
    issue(1'b0, 32'h10, '0, h);
    wait_idle();

    // Flush together with a request: refused, then everything misses.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    #1;
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; req_valid = 1'b0;
    model_reset_lines();
    issue(1'b0, 32'h10, '0, h);
    wait_idle();

    // Randomized traffic; occasional flush pulses while busy must be ignored.
    fix_ready = -1; fix_rd = -1;
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [31:0] a;
      bit          w;
      r = $urandom_range(0, 99);
      a = 32'($urandom_range(0, 15)) << 2;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 32'h1000_0000;
      if (r < 8) begin
        wait_idle();
        do_flush();
      end else begin
        w = (r < 38);
        issue(w, a, $urandom, h);
        if ((w || !h) && $urandom_range(0, 3) == 0) begin
          @(negedge clk);
          flush = 1'b1;
          @(posedge clk);
          #1;
          flush = 1'b0;
        end
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_queue_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
